// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with a retired-instruction counter.
// Optional memory-access timeout abort is enabled by defining CTRL_MEM_TIMEOUT_EN.
module multicycle_controller #(
    parameter logic [6:0] HALT_OPCODE = 7'b1111111,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             instr_ready,
    output logic             ir_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             halted,
    output logic             illegal,
    output logic             mem_error,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 1..255");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_reg, state_next;
    logic [6:0]       opcode_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             set_illegal;
    logic             retire_now;
    logic             timeout_hit;

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic is_known, is_halt;

    assign is_r      = (opcode_reg == OP_R);
    assign is_i      = (opcode_reg == OP_I);
    assign is_load   = (opcode_reg == OP_LOAD);
    assign is_store  = (opcode_reg == OP_STORE);
    assign is_branch = (opcode_reg == OP_BRANCH);
    assign is_jal    = (opcode_reg == OP_JAL);
    assign is_jalr   = (opcode_reg == OP_JALR);
    assign is_lui    = (opcode_reg == OP_LUI);
    assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui;
    assign is_halt   = (opcode_reg == HALT_OPCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            opcode_reg  <= 7'd0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ir_write) begin
                opcode_reg <= opcode;
            end
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (retire_now) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    // The only output allowed to look at a live input; everything else is Moore.
    assign ir_write = instr_valid & instr_ready;

    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        retire_now  = 1'b0;
        instr_ready = 1'b0;
        alu_src     = 1'b0;
        alu_op      = 2'b00;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        branch      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 2'b00;
        halted      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // HALT_OPCODE takes priority even if it aliases a known class.
                if (is_halt) begin
                    state_next = S_HALT;
                end else if (!is_known) begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_write = 1'b1;
                alu_src  = is_i | is_load | is_store | is_jalr | is_lui;
                if (is_r || is_i) begin
                    alu_op = 2'b10;
                end else if (is_branch) begin
                    alu_op = 2'b01;
                end
                if (is_branch) begin
                    pc_src = 2'b01;
                end else if (is_jal) begin
                    pc_src = 2'b10;
                end else if (is_jalr) begin
                    pc_src = 2'b11;
                end
                if (is_branch) begin
                    branch     = 1'b1;
                    retire_now = 1'b1;
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    state_next = is_load ? S_WB : S_FETCH;
                    retire_now = is_store;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                retire_now = 1'b1;
                state_next = S_FETCH;
                if (is_load) begin
                    mem_to_reg = 2'b01;
                end else if (is_jal || is_jalr) begin
                    mem_to_reg = 2'b10;
                end else if (is_lui) begin
                    mem_to_reg = 2'b11;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic       mem_error_reg;

    // Counter sits at zero outside MEM, so it is already cleared on MEM entry.
    assign timeout_hit = (state_reg == S_MEM) && !mem_ready
                         && (wait_cnt_reg == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg  <= 8'd0;
            mem_error_reg <= 1'b0;
        end else begin
            if (state_reg != S_MEM) begin
                wait_cnt_reg <= 8'd0;
            end else if (!mem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if (timeout_hit) begin
                mem_error_reg <= 1'b1;
            end
        end
    end

    assign mem_error = mem_error_reg;
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    assign illegal = illegal_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; define CTRL_MEM_TIMEOUT_EN to exercise the timeout abort.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        instr_ready, ir_write, alu_src, pc_write, branch;
    logic        mem_read, mem_write, reg_write, halted, illegal, mem_error;
    logic [1:0]  alu_op, pc_src, mem_to_reg;
    logic [31:0] retired;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b0001111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    multicycle_controller #(
        .HALT_OPCODE(7'b1111111),
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .instr_ready(instr_ready),
        .ir_write   (ir_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal),
        .mem_error  (mem_error),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign outs = {instr_ready, ir_write, alu_src, alu_op, pc_write, pc_src, branch,
                   mem_read, mem_write, reg_write, mem_to_reg, halted, illegal, mem_error};

    // Expected output vector, fields in the same order as outs.
    function automatic logic [16:0] ov(input logic ir, input logic iw, input logic as,
                                       input logic [1:0] aop, input logic pw, input logic [1:0] ps,
                                       input logic br, input logic mr, input logic mw, input logic rw,
                                       input logic [1:0] m2r, input logic h, input logic il,
                                       input logic me);
        return {ir, iw, as, aop, pw, ps, br, mr, mw, rw, m2r, h, il, me};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 7'd0;
        mem_ready   = 1'b0;
        tick();
        tick();
        check("rst_outs", 32'(outs), 32'(ov(1,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        check("rst_retired", retired, 32'd0);

        reset = 1'b1;
        tick();
        #1 check("fetch_idle", 32'(outs), 32'(ov(1,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));

        // R-type, zero wait
        instr_valid = 1'b1; opcode = OP_R; mem_ready = 1'b1;
        #1 check("r_fetch", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick(); opcode = 7'd0;
        #1 check("r_decode", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("r_exec", 32'(outs), 32'(ov(0,0,0,2'b10,1,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("r_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b00,0,0,0)));
        check("r_wb_ret", retired, 32'd0);
        tick(); opcode = OP_LOAD; mem_ready = 1'b0;
        #1 check("r_retired", retired, 32'd1);
        check("ld_fetch", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));

        // Load with three wait cycles
        tick();
        tick();
        #1 check("ld_exec", 32'(outs), 32'(ov(0,0,1,2'b00,1,2'b00,0,0,0,0,2'b00,0,0,0)));
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check("ld_mem_wait", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,1,0,0,2'b00,0,0,0)));
        end
        tick(); mem_ready = 1'b1;
        #1 check("ld_mem_done", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,1,0,0,2'b00,0,0,0)));
        tick();
        #1 check("ld_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b01,0,0,0)));
        tick(); opcode = OP_JAL;
        #1 check("ld_retired", retired, 32'd2);

        // JAL then JALR
        tick(); tick();
        #1 check("jal_exec", 32'(outs), 32'(ov(0,0,0,2'b00,1,2'b10,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("jal_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b10,0,0,0)));
        tick(); opcode = OP_JALR;
        tick(); tick();
        #1 check("jalr_exec", 32'(outs), 32'(ov(0,0,1,2'b00,1,2'b11,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("jalr_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b10,0,0,0)));
        tick(); opcode = OP_BRANCH;
        #1 check("jump_retired", retired, 32'd4);

        // Branch: three cycles, retires in EXEC
        tick(); tick();
        #1 check("br_exec", 32'(outs), 32'(ov(0,0,0,2'b01,1,2'b01,1,0,0,0,2'b00,0,0,0)));
        tick(); opcode = OP_STORE;
        #1 check("br_retired", retired, 32'd5);
        check("br_fetch", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));

        // Store, single-cycle access
        tick(); tick();
        #1 check("st_exec", 32'(outs), 32'(ov(0,0,1,2'b00,1,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("st_mem", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        tick(); opcode = OP_LUI;
        #1 check("st_retired", retired, 32'd6);

        // LUI and I-type
        tick(); tick();
        #1 check("lui_exec", 32'(outs), 32'(ov(0,0,1,2'b00,1,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("lui_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b11,0,0,0)));
        tick(); opcode = OP_I;
        tick(); tick();
        #1 check("i_exec", 32'(outs), 32'(ov(0,0,1,2'b10,1,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("i_wb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,1,2'b00,0,0,0)));
        tick(); instr_valid = 1'b0;
        #1 check("i_retired", retired, 32'd8);
        tick();
        #1 check("fetch_stall", 32'(outs), 32'(ov(1,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));

        // Illegal opcode
        instr_valid = 1'b1; opcode = OP_BAD;
        tick();
        #1 check("bad_decode", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick();
        #1 check("bad_halt", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,1,1,0)));
        check("bad_retired", retired, 32'd8);
        tick(); tick();
        #1 check("bad_sticky", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,1,1,0)));
        instr_valid = 1'b0; reset = 1'b0;
        #1 check("async_rst", 32'(outs), 32'(ov(1,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        check("async_rst_ret", retired, 32'd0);
        tick(); reset = 1'b1;

        // Reset mid-MEM drops the request immediately
        instr_valid = 1'b1; opcode = OP_LOAD; mem_ready = 1'b0;
        tick(); tick(); tick();
        #1 check("mid_mem", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,1,0,0,2'b00,0,0,0)));
        reset = 1'b0;
        #1 check("mid_mem_rst", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        tick(); reset = 1'b1;

        // Ten R-types, then HALT_OPCODE
        opcode = OP_R; mem_ready = 1'b1;
        repeat (40) tick();
        #1 check("ten_r_retired", retired, 32'd10);
        opcode = OP_HALT;
        tick(); tick();
        #1 check("halt_op", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,1,0,0)));
        check("halt_retired", retired, 32'd10);
        opcode = OP_R;
        tick(); tick(); tick();
        #1 check("halt_absorb", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,1,0,0)));
        check("halt_ret_hold", retired, 32'd10);

        // Store with memory stuck
        reset = 1'b0; tick(); reset = 1'b1;
        opcode = OP_STORE; mem_ready = 1'b0;
        tick(); tick();
`ifdef CTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 check("to_mem", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        end
        tick();
        #1 check("to_halt", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,0,0,2'b00,1,0,1)));
        check("to_retired", retired, 32'd0);

        reset = 1'b0; tick(); reset = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check("to_race_wait", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        end
        tick(); mem_ready = 1'b1;
        #1 check("to_race_last", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        tick();
        #1 check("to_race_fetch", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        check("to_race_ret", retired, 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            #1 check("st_wait_long", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        end
        tick(); mem_ready = 1'b1;
        #1 check("st_wait_last", 32'(outs), 32'(ov(0,0,0,2'b00,0,2'b00,0,0,1,0,2'b00,0,0,0)));
        tick();
        #1 check("st_wait_fetch", 32'(outs), 32'(ov(1,1,0,2'b00,0,2'b00,0,0,0,0,2'b00,0,0,0)));
        check("st_wait_ret", retired, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences each RISC-V instruction through fetch, decode, execute, memory and write-back.
- Covers R, I, load, store, branch, JAL, JALR, LUI and a configurable HALT opcode.
- Holds memory requests until the data memory acknowledges.
- Flags illegal opcodes, counts retired instructions, and optionally aborts on memory timeout.
- Sits between the instruction-fetch stage and the shared datapath. It drives every mux select and write enable.

## Interface

Parameters:
- `HALT_OPCODE`, default 7'b1111111: opcode that stops the core.
- `MEM_TIMEOUT`, default 16: cycles in MEM without `mem_ready` before abort. Range 1..255.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state immediately.
- `instr_valid` in 1: fetch stage presents an instruction word.
- `opcode` in 7: `instr[6:0]`, valid while `instr_valid` is high.
- `mem_ready` in 1: data memory completes the current access.
- `instr_ready` out 1: controller accepts an instruction (FETCH only).
- `ir_write` out 1: latch instruction register. Equals `instr_valid & instr_ready`.
- `alu_src` out 1: 0 selects `rs2`, 1 selects the immediate.
- `alu_op` out 2: 00 add (load/store/JALR), 01 branch compare, 10 funct-decoded (R/I).
- `pc_write` out 1: update PC this cycle.
- `pc_src` out 2: 00 PC+4, 01 branch target (the datapath qualifies it with the compare result), 10 PC+immJ, 11 (rs1+immI)&~1.
- `branch` out 1: branch instruction in EXEC.
- `mem_read` out 1: load request.
- `mem_write` out 1: store request.
- `reg_write` out 1: write `rd`.
- `mem_to_reg` out 2: 00 ALU, 01 memory data, 10 PC+4, 11 immU.
- `halted` out 1: sticky; set in HALT.
- `illegal` out 1: sticky; HALT was caused by an unknown opcode.
- `mem_error` out 1: sticky; HALT was caused by a memory timeout.
- `retired` out `CNT_W`: count of completed instructions.

## Operation

- Opcode register: captures `opcode` on `ir_write`. All decoding after FETCH uses the registered opcode.
- Outputs: every output is a function of the state and the registered opcode only. The one exception is `ir_write`.
- States and transitions:
  - FETCH: `instr_ready`=1. Moves to DECODE on `instr_valid`; otherwise stays.
  - DECODE: one cycle.
    - HALT_OPCODE goes to HALT.
    - An opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111} goes to HALT with `illegal`=1.
    - Anything else goes to EXEC.
  - EXEC: one cycle with `pc_write`=1. `pc_src` and `alu_op`/`alu_src` are set per class.
    - Branch: `branch`=1, then FETCH.
    - Load/store: go to MEM.
    - All other classes: go to WB.
  - MEM: `mem_read` (load) or `mem_write` (store) is held high until `mem_ready`.
    - On `mem_ready`, a load goes to WB and a store goes to FETCH.
  - WB: `reg_write`=1 with `mem_to_reg` per class (load 01, JAL/JALR 10, LUI 11, R/I 00), then FETCH.
  - HALT: absorbing. `halted`=1 and all enables are 0. Only `reset` leaves it.
- `retired` increments by 1 on the last cycle of each completed instruction:
  - EXEC for a branch,
  - MEM with `mem_ready` for a store,
  - WB for everything else.
- HALT itself does not retire. `retired` wraps modulo 2^`CNT_W`.
- Reset: state becomes FETCH and every output is 0 except `instr_ready`=1. `retired`=0 and the sticky flags clear. Reset mid-MEM drops the request at once; memory must tolerate an aborted access.

## Timing

- Minimum cycles per instruction with `instr_valid` already high and zero-wait memory:
  - branch: 3
  - R/I/LUI/JAL/JALR/store: 4
  - load: 5
- Each cycle of `instr_valid` low in FETCH and each cycle of `mem_ready` low in MEM adds one cycle.
- `mem_ready` sampled high in the first MEM cycle gives a single-cycle access.
- `pc_write` is asserted exactly once per retired instruction.

## Configuration

- `CTRL_MEM_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on MEM entry and increments on each MEM cycle with `mem_ready` low.
  - When the counter reaches `MEM_TIMEOUT`, the FSM goes to HALT with `mem_error`=1 and drops the request.
  - If `mem_ready` is high in the same cycle the limit is reached, `mem_ready` wins and the access completes normally.
- `CTRL_MEM_TIMEOUT_EN` undefined:
  - MEM waits indefinitely.
  - `mem_error` is tied to 0 and no counter is synthesised.

## Test plan

- Reset release, `instr_valid`=1, opcode 0110011, `mem_ready`=1 → DECODE, EXEC (`pc_write`=1, `pc_src`=00, `alu_op`=10), WB (`reg_write`=1, `mem_to_reg`=00); `retired`=1 after 4 cycles.
- Load 0000011 with `mem_ready` low for 3 MEM cycles → `mem_read` high for exactly 4 cycles, then WB with `mem_to_reg`=01; total 8 cycles; `retired`+1.
- JAL 1101111 then JALR 1100111 → EXEC shows `pc_src`=10 then 11; both WB cycles show `mem_to_reg`=10; `retired`=2.
- Opcode 0001111 → HALT two cycles after accept with `illegal`=1 and `instr_ready`=0 permanently; `retired` unchanged. Then `reset` low for 1 cycle → all flags 0, state FETCH.
- `CTRL_MEM_TIMEOUT_EN` defined, `MEM_TIMEOUT`=4, store with `mem_ready` stuck low → `mem_write` high 4 cycles, then `halted`=`mem_error`=1. Repeat with `mem_ready` rising on the 4th cycle → store retires and no error.
- HALT_OPCODE 1111111 after 10 R-type instructions → `halted`=1, `retired`=10, no further `ir_write` despite `instr_valid`=1.
